// File: rtl/jtframe_scan2x_dbl_if.sv
// Video bus between the game side (base rate) and the doubler (x2 rate).
interface jtframe_scan2x_dbl_if #(
  parameter int DW = 8
);
  logic          base_cen;
  logic          basex2_cen;
  logic [DW-1:0] base_pxl;
  logic          HS;
  logic [DW-1:0] x2_pxl;
  logic          x2_HS;

  modport master (
    output base_cen, basex2_cen, base_pxl, HS,
    input  x2_pxl, x2_HS
  );

  modport slave (
    input  base_cen, basex2_cen, base_pxl, HS,
    output x2_pxl, x2_HS
  );
endinterface

// File: rtl/jtframe_scan2x_dbl.sv
// 15 kHz -> 31 kHz line doubler: ping-pong line buffer, each captured line
// is replayed twice at basex2_cen rate with a locally generated HSync.
module jtframe_scan2x_dbl #(
  parameter int DW     = 8,
  parameter int HLEN   = 640,
  parameter int HS_LEN = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  jtframe_scan2x_dbl_if.slave    bus
);
  localparam int AW = (HLEN > 1) ? $clog2(HLEN) : 1;
  localparam logic [AW-1:0] LAST = AW'(HLEN - 1);
  localparam logic [AW-1:0] HSL  = AW'(HS_LEN);

  logic [DW-1:0] mem [2][HLEN];

  logic          hs_l_q;
  logic          wbank_q, wbank_d;
  logic [AW-1:0] wraddr_q, wraddr_d;
  logic [AW-1:0] rdaddr_q, rdaddr_d;
  logic [DW-1:0] x2_pxl_q;
  logic          x2_hs_q;

  logic          hs_rise;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] rd_word;

  // The edge takes effect in the same clk: a coincident write lands at
  // address 0 of the new bank and a coincident read fetches the line just done.
  always_comb begin
    hs_rise  = bus.HS & ~hs_l_q;
    wbank_d  = wbank_q ^ hs_rise;
    wa       = hs_rise ? '0 : wraddr_q;
    ra       = hs_rise ? '0 : rdaddr_q;
    wraddr_d = wa;
    if (bus.base_cen && wa != LAST) wraddr_d = wa + 1'b1;
    rdaddr_d = ra;
    if (bus.basex2_cen) rdaddr_d = (ra == LAST) ? '0 : ra + 1'b1;
    rd_word  = mem[~wbank_d][ra];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_l_q   <= 1'b0;
      wbank_q  <= 1'b0;
      wraddr_q <= '0;
      rdaddr_q <= '0;
      x2_pxl_q <= '0;
      x2_hs_q  <= 1'b0;
    end else begin
      hs_l_q   <= bus.HS;
      wbank_q  <= wbank_d;
      wraddr_q <= wraddr_d;
      rdaddr_q <= rdaddr_d;
      if (bus.basex2_cen) begin
        x2_pxl_q <= rd_word;
        x2_hs_q  <= (ra < HSL);
      end
    end
  end

  // Line buffer contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && bus.base_cen) mem[wbank_d][wa] <= bus.base_pxl;
  end

  assign bus.x2_pxl = x2_pxl_q;
  assign bus.x2_HS  = x2_hs_q;
endmodule

// File: tb/tb_jtframe_scan2x_dbl.sv
// Directed bench for the line doubler: per-cycle model comparison plus
// literal expectations on captured replay sequences.
module tb_jtframe_scan2x_dbl;
  localparam int DW = 8, HLEN = 8, HS_LEN = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jtframe_scan2x_dbl_if #(.DW(DW)) bus ();

  jtframe_scan2x_dbl #(.DW(DW), .HLEN(HLEN), .HS_LEN(HS_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: line buffer as two arrays, pixel and replay counts since the last edge.
  logic [DW-1:0] m_mem [2][HLEN];
  bit            m_kv  [2][HLEN];
  int            m_bank = 0, m_wcnt = 0, m_rcnt = 0;
  bit            m_hsl = 0;
  logic [DW-1:0] e_pxl;
  bit            e_hs, e_pxl_known = 0, e_valid = 0;

  bit            cap_en = 0;
  logic [DW-1:0] cap_pxl[$];
  bit            cap_hs[$];

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < HLEN; a++) m_kv[b][a] = 0;
    forever begin
      @(posedge clk);
      begin
        bit bc, xc, hs;
        logic [DW-1:0] px;
        bc = bus.base_cen; xc = bus.basex2_cen; hs = bus.HS; px = bus.base_pxl;
        if (rst) begin
          m_bank = 0; m_wcnt = 0; m_rcnt = 0; m_hsl = 0;
          e_pxl = '0; e_hs = 0; e_pxl_known = 1; e_valid = 1;
        end else begin
          if (hs && !m_hsl) begin
            m_bank ^= 1; m_wcnt = 0; m_rcnt = 0;
          end
          m_hsl = hs;
          if (bc) begin
            int a;
            a = (m_wcnt < HLEN) ? m_wcnt : HLEN - 1;
            m_mem[m_bank][a] = px; m_kv[m_bank][a] = 1;
            m_wcnt++;
          end
          if (xc) begin
            int a;
            a = m_rcnt % HLEN;
            e_pxl = m_mem[1 - m_bank][a]; e_pxl_known = m_kv[1 - m_bank][a];
            e_hs = (a < HS_LEN);
            m_rcnt++;
          end
        end
        #1;
        if (e_valid) begin
          chk("x2_HS", {31'd0, bus.x2_HS}, {31'd0, e_hs});
          if (e_pxl_known) chk("x2_pxl", {24'd0, bus.x2_pxl}, {24'd0, e_pxl});
        end
        if (cap_en && xc && !rst) begin
          cap_pxl.push_back(bus.x2_pxl);
          cap_hs.push_back(bus.x2_HS);
        end
      end
    end
  end

  task automatic step(input bit bc, input bit xc, input logic [DW-1:0] px, input bit hs, input bit r);
    @(negedge clk);
    bus.base_cen = bc; bus.basex2_cen = xc; bus.base_pxl = px; bus.HS = hs; rst = r;
  endtask

  // A line: HS rises on the first clk together with both cens; base_cen every
  // 4 clks, basex2_cen every 2 clks. Optional check right after the edge clk.
  task automatic send_line(input int first, input int npix, input bit chk_sim, input int exp0);
    for (int i = 0; i < npix * 4; i++) begin
      if (chk_sim && i == 1) begin
        @(negedge clk);
        chk("sim_x2_pxl", {24'd0, bus.x2_pxl}, exp0);
        chk("sim_wraddr", 32'(dut.wraddr_q), 32'd1);
        chk("sim_rdaddr", 32'(dut.rdaddr_q), 32'd1);
      end
      step(i % 4 == 0, i % 2 == 0, DW'(first + i / 4), i == 0, 1'b0);
    end
  endtask

  task automatic check_cap(input string name, input int n, input logic [DW-1:0] exp_p[$]);
    chk({name, "_len"}, 32'(cap_pxl.size()) >= 32'(n) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < n && k < cap_pxl.size(); k++) begin
      chk({name, "_pxl"}, {24'd0, cap_pxl[k]}, {24'd0, exp_p[k % exp_p.size()]});
      chk({name, "_hs"}, {31'd0, cap_hs[k]}, {31'd0, 1'((k % HLEN) < HS_LEN)});
    end
    cap_pxl.delete(); cap_hs.delete();
  endtask

  initial begin
    logic [DW-1:0] ex[$];
    bus.base_cen = 0; bus.basex2_cen = 0; bus.base_pxl = '0; bus.HS = 0;
    // reset with cens toggling
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_x2_pxl", {24'd0, bus.x2_pxl}, 32'd0);
    chk("rst_x2_HS", {31'd0, bus.x2_HS}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
    chk("idle_x2_pxl", {24'd0, bus.x2_pxl}, 32'd0);
    chk("idle_wbank", 32'(dut.wbank_q), 32'd0);

    // doubling: A = 1..8, B = 11..18, during B expect A twice
    send_line(1, 8, 1'b0, 0);
    cap_en = 1;
    send_line(11, 8, 1'b0, 0);
    cap_en = 0;
    ex = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    check_cap("dbl", 16, ex);

    // ping-pong: during C expect B twice, no A data
    cap_en = 1;
    send_line(21, 8, 1'b0, 0);
    cap_en = 0;
    ex = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
    check_cap("pp", 16, ex);

    // overlong line D = 31..40; line E starts with a coincident edge
    send_line(31, 10, 1'b0, 0);
    cap_en = 1;
    send_line(41, 8, 1'b1, 31);
    cap_en = 0;
    ex = '{8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd40};
    check_cap("ovl", 16, ex);

    // mid-line reset
    send_line(51, 4, 1'b0, 0);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("mrst_wraddr", 32'(dut.wraddr_q), 32'd0);
    chk("mrst_rdaddr", 32'(dut.rdaddr_q), 32'd0);
    chk("mrst_wbank", 32'(dut.wbank_q), 32'd0);
    chk("mrst_x2_pxl", {24'd0, bus.x2_pxl}, 32'd0);
    send_line(61, 8, 1'b0, 0);
    cap_en = 1;
    send_line(71, 8, 1'b0, 0);
    cap_en = 0;
    ex = '{8'd61, 8'd62, 8'd63, 8'd64, 8'd65, 8'd66, 8'd67, 8'd68};
    check_cap("mrst", 16, ex);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
